// File: rtl/rom_pkg.sv
// Shared definitions for the ROM burst fetch sequencer.
package rom_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rom_fetch_seq_if.sv
// Burst request and stream handshake between the fetch sequencer and its user.
interface rom_fetch_seq_if
    import rom_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, length, ready,
        input  data_out, valid, busy, done
    );

    modport slave (
        input  start, base_addr, length, ready,
        output data_out, valid, busy, done
    );

endinterface

// File: rtl/rom_fetch_seq.sv
// Streams a burst of consecutive words out of a combinational ROM with a
// valid/ready output register.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; Address holds its last value
// ST_RUN   | words still to be fetched from the ROM
// ST_DRAIN | all words fetched, waiting for the last one to be taken
module rom_fetch_seq
    import rom_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] rom_data,
    rom_fetch_seq_if.slave    bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // A zero-length request completes at once without touching Address.
                    if (bus.length != '0) begin
                        addr_d  = bus.base_addr;
                        rem_d   = bus.length;
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                load = (!valid_q || bus.ready) && (rem_q != '0);
                if (load) begin
                    data_d  = rom_data;
                    valid_d = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                    rem_d   = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end else if (valid_q && bus.ready) begin
                    valid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (valid_q && bus.ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Address      = addr_q;
    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_rom_fetch_seq.sv
// Directed bench for rom_fetch_seq with a behavioural ROM holding data[i] = i ^ 8'hA5.
module tb_rom_fetch_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] rom_data;
    int         n_checks;
    int         n_errors;

    typedef struct {
        logic [7:0]  base;
        logic [8:0]  len;
        logic [15:0] rdy;
        logic [7:0]  first;
        logic [7:0]  end_addr;
        bit          restart;
    } vec_t;

    vec_t vecs [6];

    rom_fetch_seq_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    rom_fetch_seq #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Address  (addr),
        .rom_data (rom_data),
        .bus      (bus.slave)
    );

    assign rom_data = addr ^ 8'hA5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int         idx;
        int         last_hs;
        bit         fin;
        logic       pv, pr;
        logic [7:0] pd, pa, a;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = v.base;
        bus.length    = v.len;
        bus.ready     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.base_addr = 8'h77;
        bus.length    = 9'd9;
        chk("addr_after_start", addr, v.base);
        chk("busy_after_start", bus.busy, 1);
        chk("valid_after_start", bus.valid, 0);
        @(negedge clk);
        chk("first_valid", bus.valid, 1);
        chk("first_data", bus.data_out, v.first);
        idx = 0;
        last_hs = -10;
        fin = 1'b0;
        pv = 1'b0;
        pr = 1'b1;
        pd = '0;
        pa = '0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (bus.done) begin
                chk("done_after_last", last_hs, cyc - 1);
                chk("done_valid_excl", bus.valid, 0);
                chk("done_busy", bus.busy, 0);
                fin = 1'b1;
            end else begin
                chk("busy_in_burst", bus.busy, 1);
                if (pv && !pr) begin
                    chk("hold_valid", bus.valid, 1);
                    chk("hold_data", bus.data_out, pd);
                    chk("hold_addr", addr, pa);
                end
                bus.start = v.restart && (cyc == 2);
                bus.ready = v.rdy[cyc % 16];
                if (bus.valid && bus.ready) begin
                    a = v.base + 8'(idx);
                    chk("word", bus.data_out, a ^ 8'hA5);
                    idx++;
                    last_hs = cyc;
                end
                pv = bus.valid;
                pr = bus.ready;
                pd = bus.data_out;
                pa = addr;
                @(negedge clk);
            end
        end
        if (!fin) chk("burst_timeout", 0, 1);
        chk("word_count", idx, v.len);
        chk("end_addr", addr, v.end_addr);
        bus.start = 1'b0;
        bus.ready = 1'b1;
        @(negedge clk);
        chk("done_single", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{base: 8'h10, len: 9'd4, rdy: 16'hFFFF, first: 8'hB5, end_addr: 8'h14, restart: 1'b0};
        vecs[1] = '{base: 8'hFE, len: 9'd4, rdy: 16'hFFFF, first: 8'h5B, end_addr: 8'h02, restart: 1'b0};
        vecs[2] = '{base: 8'h20, len: 9'd3, rdy: 16'hFFF9, first: 8'h85, end_addr: 8'h23, restart: 1'b0};
        vecs[3] = '{base: 8'h00, len: 9'd1, rdy: 16'hFFFF, first: 8'hA5, end_addr: 8'h01, restart: 1'b0};
        vecs[4] = '{base: 8'h80, len: 9'd5, rdy: 16'hAAAA, first: 8'h25, end_addr: 8'h85, restart: 1'b0};
        vecs[5] = '{base: 8'h50, len: 9'd6, rdy: 16'hFFFF, first: 8'hF5, end_addr: 8'h56, restart: 1'b1};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.ready     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_addr", addr, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", bus.valid, 0);
        chk("idle_busy0", bus.busy, 0);

        for (int i = 0; i < 6; i++) run_burst(vecs[i]);

        // Zero-length request: done next cycle, no data, Address untouched.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 8'h99;
        bus.length    = 9'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("len0_done", bus.done, 1);
        chk("len0_valid", bus.valid, 0);
        chk("len0_busy", bus.busy, 0);
        chk("len0_addr", addr, 8'h56);
        @(negedge clk);
        chk("len0_done_once", bus.done, 0);
        chk("len0_valid_after", bus.valid, 0);

        run_burst('{base: 8'h00, len: 9'd256, rdy: 16'hFFFF, first: 8'hA5, end_addr: 8'h00, restart: 1'b0});

        // Reset in the middle of a burst.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 8'h40;
        bus.length    = 9'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_valid_pre", bus.valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_data", bus.data_out, 0);
        chk("mid_rst_valid", bus.valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_valid", bus.valid, 0);
        end
        run_burst('{base: 8'h30, len: 9'd2, rdy: 16'hFFFF, first: 8'h95, end_addr: 8'h32, restart: 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
